// File: rtl/test_phase_ctrl.sv
// Per-router self-test phase sequencer: TD -> ACK -> BORDER -> FINISH, with
// per-link ack capture into a faulty-link vector, re-arm via start and a done pulse.
module test_phase_ctrl #(
  parameter int unsigned ROUTERID     = 0,
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned TD_CYCLES    = 6,
  parameter int unsigned ACK_END      = 76,
  parameter int unsigned BORDER_STEP  = 2,
  parameter int unsigned GUARD_CYCLES = 10,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_PORTS-1:0] ack_valid,
  output logic                 test_set,
  output logic [1:0]           phase,
  output logic [NUM_PORTS-1:0] faulty,
  output logic                 done,
  output logic [CNT_W-1:0]     counter
);

  localparam int unsigned BORDER_END_I = ACK_END + ROUTERID * BORDER_STEP;
  localparam int unsigned END_I        = BORDER_END_I + GUARD_CYCLES;

  if (!(TD_CYCLES > 0 && TD_CYCLES < ACK_END &&
        64'(END_I) <= ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_params
    $error("test_phase_ctrl: illegal phase lengths for CNT_W");
  end

  localparam logic [CNT_W-1:0] TD_C       = CNT_W'(TD_CYCLES);
  localparam logic [CNT_W-1:0] ACK_END_C  = CNT_W'(ACK_END);
  localparam logic [CNT_W-1:0] ACK_LAST_C = CNT_W'(ACK_END - 1);
  localparam logic [CNT_W-1:0] BORDER_C   = CNT_W'(BORDER_END_I);
  localparam logic [CNT_W-1:0] END_C      = CNT_W'(END_I);

  typedef enum logic [1:0] {
    PH_TD     = 2'b00,
    PH_ACK    = 2'b01,
    PH_BORDER = 2'b10,
    PH_FINISH = 2'b11
  } phase_t;

  phase_t               phase_q, phase_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] seen_q, seen_d;
  logic [NUM_PORTS-1:0] faulty_q, faulty_d;
  logic                 done_q, done_d;

  function automatic phase_t phase_of(input logic [CNT_W-1:0] c);
    if (c < TD_C)           return PH_TD;
    else if (c < ACK_END_C) return PH_ACK;
    else if (c < BORDER_C)  return PH_BORDER;
    else                    return PH_FINISH;
  endfunction

  always_comb test_set = (cnt_q < END_C);

  always_comb begin
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    faulty_d = faulty_q;
    done_d   = 1'b0;
    if (test_set) begin
      cnt_d  = cnt_q + CNT_W'(1);
      done_d = (cnt_d == END_C);
      if (phase_q == PH_ACK) seen_d = seen_q | ack_valid;
      // seen_d already includes this cycle's acks, so a last-cycle ack counts
      if (cnt_q == ACK_LAST_C) begin
        faulty_d = ~seen_d;
        seen_d   = '0;
      end
    end else if (start) begin
      cnt_d    = '0;
      seen_d   = '0;
      faulty_d = '0;
    end
    // Phase follows the next counter value so it stays aligned with counter.
    phase_d = phase_of(cnt_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      phase_q  <= PH_TD;
      seen_q   <= '0;
      faulty_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      seen_q   <= seen_d;
      faulty_q <= faulty_d;
      done_q   <= done_d;
    end
  end

  assign counter = cnt_q;
  assign phase   = phase_q;
  assign faulty  = faulty_q;
  assign done    = done_q;

endmodule

// File: tb/tb_test_phase_ctrl.sv
// Randomized bench for test_phase_ctrl: two routers (ROUTERID 3 and 0) share
// inputs and are checked every cycle against an elapsed-time reference model.
module tb_test_phase_ctrl;

  localparam int unsigned NP = 4;
  localparam int unsigned TD = 6;
  localparam int unsigned AE = 76;
  localparam int unsigned BS = 2;
  localparam int unsigned GC = 10;
  localparam int unsigned CW = 8;
  localparam int unsigned NCYC = 5000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NP-1:0] ack;

  logic          ts_o  [2];
  logic [1:0]    ph_o  [2];
  logic [NP-1:0] fl_o  [2];
  logic          dn_o  [2];
  logic [CW-1:0] cn_o  [2];

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned rid [2] = '{3, 0};
  string       nm  [2] = '{"r3", "r0"};

  // Reference model: elapsed cycles in the current run, saturating at E.
  int unsigned   m_t     [2];
  logic [NP-1:0] m_seen  [2];
  logic [NP-1:0] m_faulty[2];
  logic          m_done  [2];

  always #5 clk = ~clk;

  test_phase_ctrl #(
    .ROUTERID(3), .NUM_PORTS(NP), .TD_CYCLES(TD), .ACK_END(AE),
    .BORDER_STEP(BS), .GUARD_CYCLES(GC), .CNT_W(CW)
  ) dut3 (
    .clk(clk), .reset(reset), .start(start), .ack_valid(ack),
    .test_set(ts_o[0]), .phase(ph_o[0]), .faulty(fl_o[0]),
    .done(dn_o[0]), .counter(cn_o[0])
  );

  test_phase_ctrl #(
    .ROUTERID(0), .NUM_PORTS(NP), .TD_CYCLES(TD), .ACK_END(AE),
    .BORDER_STEP(BS), .GUARD_CYCLES(GC), .CNT_W(CW)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .ack_valid(ack),
    .test_set(ts_o[1]), .phase(ph_o[1]), .faulty(fl_o[1]),
    .done(dn_o[1]), .counter(cn_o[1])
  );

  function automatic int unsigned border_end(input int k);
    return AE + rid[k] * BS;
  endfunction

  function automatic int unsigned run_end(input int k);
    return border_end(k) + GC;
  endfunction

  function automatic logic [1:0] exp_phase(input int k, input int unsigned t);
    if (t < TD)                 return 2'b00;
    else if (t < AE)            return 2'b01;
    else if (t < border_end(k)) return 2'b10;
    else                        return 2'b11;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_t[k] = 0; m_seen[k] = '0; m_faulty[k] = '0; m_done[k] = 1'b0;
      end else if (m_t[k] < run_end(k)) begin
        if (m_t[k] >= TD && m_t[k] < AE) m_seen[k] |= ack;
        if (m_t[k] == AE - 1) begin
          m_faulty[k] = ~m_seen[k];
          m_seen[k]   = '0;
        end
        m_t[k]++;
        m_done[k] = (m_t[k] == run_end(k));
      end else begin
        m_done[k] = 1'b0;
        if (start) begin
          m_t[k] = 0; m_seen[k] = '0; m_faulty[k] = '0;
        end
      end
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check({nm[k], ".counter"},  32'(cn_o[k]), 32'(m_t[k]));
      check({nm[k], ".test_set"}, 32'(ts_o[k]), 32'(m_t[k] < run_end(k)));
      check({nm[k], ".phase"},    32'(ph_o[k]), 32'(exp_phase(k, m_t[k])));
      check({nm[k], ".faulty"},   32'(fl_o[k]), 32'(m_faulty[k]));
      check({nm[k], ".done"},     32'(dn_o[k]), 32'(m_done[k]));
    end
  endtask

  initial begin
    int unsigned mode;
    bit          hold_start;
    mode = 0;
    hold_start = 1'b0;
    reset = 1'b0;
    start = 1'b0;
    ack   = '0;
    repeat (2) begin
      @(posedge clk);
      model_step();
      #1 check_all();
    end

    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // Choose a fresh ack pattern whenever router 3 begins a run.
      if (m_t[0] == 0) begin
        mode       = $urandom_range(0, 5);
        hold_start = ($urandom_range(0, 3) == 0);
      end
      case (mode)
        0: ack = '1;
        1: ack = {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)};
        2: ack = NP'($urandom);
        3: ack = (m_t[0] == 75) ? 4'b0010 : (m_t[0] == 76) ? 4'b1000 : 4'b0000;
        4: ack = '0;
        default: ack = (m_t[0] == 20) ? 4'b0101 :
                       (m_t[0] < TD || m_t[0] >= AE) ? 4'b1111 : 4'b0000;
      endcase
      if (hold_start)              start = 1'b1;
      else if (m_t[0] >= run_end(0)) start = ($urandom_range(0, 2) == 0);
      else                         start = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 399) != 0);
      @(posedge clk);
      model_step();
      #1 check_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_phase_ctrl.md
Name: test_phase_ctrl

Overview:
Per-router self-test phase sequencer for the hypercube NoC. It supersedes the fixed-length detect controller with these additions:
- parametrised phase lengths and per-router border stagger
- per-link acknowledgement capture producing a faulty-link vector
- a re-arm input for repeated test runs and a completion pulse

One instance sits in each router. test_set gates the router's test-data and ack logic.

Parameters:
ROUTERID, 0, router index; scales the border-check stagger.
NUM_PORTS, 4, number of hypercube links monitored (one ack bit per link).
TD_CYCLES, 6, length of the test-data phase in cycles.
ACK_END, 76, counter value at which the ACK phase ends.
BORDER_STEP, 2, border-check cycles per unit of ROUTERID.
GUARD_CYCLES, 10, cycles test_set stays high after the border phase ends.
CNT_W, 8, phase counter width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  re-arm request; honoured only while test_set=0
ack_valid  in  NUM_PORTS  per-link acknowledgement strobe from neighbour routers
test_set  out  1  high while a test run is in progress
phase  out  2  current phase: 00 TD, 01 ACK, 10 BORDER, 11 FINISH
faulty  out  NUM_PORTS  bit i=1: link i gave no ack during the last ACK phase
done  out  1  one-cycle pulse when a run completes
counter  out  CNT_W  current phase counter value

Behaviour:
Derived constants:
- BORDER_END = ACK_END + ROUTERID*BORDER_STEP
- E = BORDER_END + GUARD_CYCLES
- Legal parameters require 0 < TD_CYCLES < ACK_END and E <= 2^CNT_W-1. The RTL flags a violation at elaboration.

Reset (reset=0 at a clk edge):
- counter=0, phase=TD, faulty=0, ack_seen=0, done=0.
- test_set is combinational from counter, so it is 1 immediately. A run therefore starts automatically after reset release.
- Reset mid-run aborts the run with the same values. No done pulse is generated.

Counter and test_set:
- test_set = (counter < E), purely combinational.
- counter increments by 1 on each clk while test_set=1. It holds at E while test_set=0 and never wraps.

Phase register:
- phase is registered and computed from the next counter value, so it is always aligned with the counter.
- TD for counter in [0, TD_CYCLES).
- ACK for counter in [TD_CYCLES, ACK_END).
- BORDER for counter in [ACK_END, BORDER_END). With ROUTERID=0 this phase is skipped and ACK goes directly to FINISH.
- FINISH for counter >= BORDER_END, including while idle at E.

Ack capture:
- While phase=ACK, ack_seen[i] is set sticky on ack_valid[i]=1.
- On the edge where counter moves from ACK_END-1 to ACK_END: faulty <= ~(ack_seen | ack_valid), so an ack in the final ACK cycle counts. ack_seen is then cleared.
- ack_valid is ignored in all other phases.
- faulty holds its value until the next accepted start or reset.

done:
- Registered. done=1 for exactly the one cycle in which counter first equals E, i.e. the first cycle with test_set=0.

start:
- While test_set=1, start is ignored.
- While test_set=0 and start=1, the next edge sets counter=0, phase=TD, faulty=0, ack_seen=0, and test_set returns to 1.
- If start is held high continuously, each completed run re-arms on the first idle cycle.
- reset has priority over start.

Test Plan:
1. Defaults, ROUTERID=3, all ack_valid high throughout ACK, release reset -> TD for counter 0-5, ACK 6-75, BORDER 76-81, FINISH 82+; test_set falls when counter=92; done high exactly that cycle; faulty=0000; counter holds at 92.
2. NUM_PORTS=4, ack_valid pulsed only on links 0 and 2 at counter 20 -> faulty=1010 from the cycle counter=76 onward; unchanged through FINISH and idle.
3. ROUTERID=0 -> no BORDER cycle; phase ACK at 75, FINISH at 76; test_set low and done pulse at counter=86.
4. Only ack on link 1 at counter 75 and link 3 at counter 76 -> faulty=1101 (the link-1 ack counts, the link-3 ack is too late).
5. start pulse at counter 40 -> ignored, run unchanged. start after done -> next cycle counter=0, phase=TD, faulty=0000, test_set=1; the second run repeats scenario 1 timing exactly.
6. reset low for one cycle at counter 40 with acks already seen -> next cycle counter=0, phase=TD, ack_seen cleared, no done pulse; a run with no acks afterwards gives faulty=1111.
